// File: rtl/vram_port_arbiter.sv
// Round-robin arbiter giving NUM_PORTS bus requesters access to one synchronous dual-byte VRAM,
// with programmable wait states, latched read data and a per-port DTACK_N handshake.
module vram_port_arbiter #(
    parameter int unsigned  NUM_PORTS   = 2,
    parameter int unsigned  ADDR_W      = 15,
    parameter int unsigned  WAIT_STATES = 1,
    localparam int unsigned GrantW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_PORTS-1:0]        sel_i,
    input  logic [NUM_PORTS-1:0]        rnw_i,
    input  logic [NUM_PORTS-1:0]        uds_n_i,
    input  logic [NUM_PORTS-1:0]        lds_n_i,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr_i,
    input  logic [NUM_PORTS*16-1:0]     di_i,
    output logic [15:0]                 do_o,
    output logic [NUM_PORTS-1:0]        dtack_n_o,
    output logic [ADDR_W-1:0]           vram_addr_o,
    output logic [15:0]                 vram_di_o,
    input  logic [15:0]                 vram_do_i,
    output logic                        vram_ce_n_o,
    output logic                        vram_we_n_o,
    output logic                        vram_ub_n_o,
    output logic                        vram_lb_n_o,
    output logic [GrantW-1:0]           grant_o
);

    typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

    localparam logic [3:0]      CntInit = 4'(WAIT_STATES - 1);
    localparam logic [GrantW:0] NumP    = (GrantW + 1)'(NUM_PORTS);
    localparam logic [GrantW-1:0] LastInit = GrantW'(NUM_PORTS - 1);

    state_e               state_q;
    logic [GrantW-1:0]    grant_q;
    logic [GrantW-1:0]    last_q;
    logic [3:0]           cnt_q;
    logic                 capture_q;
    logic                 rnw_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [15:0]          di_q;
    logic [15:0]          do_q;
    logic                 ce_n_q;
    logic                 we_n_q;
    logic                 ub_n_q;
    logic                 lb_n_q;
    logic [NUM_PORTS-1:0] dtack_n_q;

    logic                 any_req;
    logic [GrantW-1:0]    winner;
    logic [GrantW:0]      cand;

    // Search starts one past the last granted port and wraps, so the first hit is the winner.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            cand = {1'b0, last_q} + (GrantW + 1)'(i);
            if (cand >= NumP) begin
                cand = cand - NumP;
            end
            if (!any_req && sel_i[cand[GrantW-1:0]]) begin
                any_req = 1'b1;
                winner  = cand[GrantW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            last_q    <= LastInit;
            cnt_q     <= '0;
            capture_q <= 1'b0;
            rnw_q     <= 1'b1;
            addr_q    <= '0;
            di_q      <= '0;
            do_q      <= '0;
            ce_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
            dtack_n_q <= '1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        grant_q   <= winner;
                        rnw_q     <= rnw_i[winner];
                        addr_q    <= addr_i[32'(winner) * ADDR_W +: ADDR_W];
                        di_q      <= di_i[32'(winner) * 16 +: 16];
                        cnt_q     <= CntInit;
                        capture_q <= 1'b0;
                        // Both byte strobes high is a null cycle: acknowledged, memory untouched.
                        ce_n_q    <= uds_n_i[winner] & lds_n_i[winner];
                        we_n_q    <= rnw_i[winner];
                        ub_n_q    <= uds_n_i[winner];
                        lb_n_q    <= lds_n_i[winner];
                        state_q   <= StAccess;
                    end
                end
                StAccess: begin
                    if (capture_q) begin
                        // Strobes dropped last cycle; the RAM output now holds the final read.
                        if (rnw_q) begin
                            do_q <= vram_do_i;
                        end
                        last_q    <= grant_q;
                        dtack_n_q <= ~(NUM_PORTS'(1) << grant_q);
                        capture_q <= 1'b0;
                        state_q   <= StAck;
                    end else if (cnt_q == 4'd0) begin
                        ce_n_q    <= 1'b1;
                        we_n_q    <= 1'b1;
                        ub_n_q    <= 1'b1;
                        lb_n_q    <= 1'b1;
                        capture_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StAck: begin
                    if (!sel_i[grant_q]) begin
                        dtack_n_q <= '1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign do_o        = do_q;
    assign dtack_n_o   = dtack_n_q;
    assign vram_addr_o = addr_q;
    assign vram_di_o   = di_q;
    assign vram_ce_n_o = ce_n_q;
    assign vram_we_n_o = we_n_q;
    assign vram_ub_n_o = ub_n_q;
    assign vram_lb_n_o = lb_n_q;
    assign grant_o     = grant_q;

endmodule

// File: doc/vram_port_arbiter.md
# vram_port_arbiter

Parametrised multi-requester VRAM access controller. It replaces the single-requester, fixed one-cycle IDLE/VRAM_OPERATING DTACK generator. It sits between N bus requesters (VDP fetch, VDP DMA, CPU-side ports) and one synchronous dual-byte VRAM. It arbitrates round-robin, holds the memory strobes for a configurable number of wait states, latches read data, and runs a full 68k-style DTACK_N handshake per port.

## Interface
Parameters:
- NUM_PORTS, 2, number of requesters (1..8)
- ADDR_W, 15, word-address width
- WAIT_STATES, 1, cycles the memory strobes are held per access (1..15); read data is valid from VRAM one cycle after strobe

Ports:
- CLK  in  1  single clock, all logic on rising edge
- RST_N  in  1  asynchronous, active-low reset
- SEL  in  NUM_PORTS  per-port request, level, held until DTACK_N seen low
- RNW  in  NUM_PORTS  per-port 1 = read, 0 = write
- UDS_N  in  NUM_PORTS  per-port upper byte strobe, active low
- LDS_N  in  NUM_PORTS  per-port lower byte strobe, active low
- ADDR  in  NUM_PORTS*ADDR_W  packed word addresses, port i at [i*ADDR_W +: ADDR_W]
- DI  in  NUM_PORTS*16  packed write data
- DO  out  16  read data for the currently acknowledged port
- DTACK_N  out  NUM_PORTS  per-port acknowledge, active low
- VRAM_ADDR  out  ADDR_W  memory word address
- VRAM_DI  out  16  memory write data
- VRAM_DO  in  16  memory read data
- VRAM_CE_N, VRAM_WE_N, VRAM_UB_N, VRAM_LB_N  out  1 each  memory strobes, active low
- GRANT  out  clog2(NUM_PORTS) (min 1)  index of port owning the current transaction, debug/observability

## Operation
- States: IDLE, ACCESS, ACK.
- IDLE: if any SEL bit is set, pick the winner round-robin. The search starts at (last_grant+1) mod NUM_PORTS. Latch the winner's index, RNW, UDS_N, LDS_N, ADDR and DI. Load the wait counter with WAIT_STATES-1 and go to ACCESS. If no SEL bit is set, stay in IDLE.
- ACCESS:
  - VRAM_CE_N=0.
  - VRAM_WE_N = latched RNW (0 on a write).
  - VRAM_UB_N and VRAM_LB_N = latched strobes.
  - VRAM_ADDR and VRAM_DI come from the latches.
  - The counter decrements each cycle. When it reaches 0: capture VRAM_DO into the DO register (read only; DO is unchanged on a write), set last_grant = winner, go to ACK.
- ACK:
  - DTACK_N[winner]=0 and all other DTACK_N bits are 1.
  - All VRAM strobes are deasserted.
  - Stay in ACK while SEL[winner]=1. When SEL[winner]=0 is sampled, go to IDLE.
- Both strobes high (UDS_N=LDS_N=1) with SEL set: the transaction still runs and is acknowledged, but VRAM_CE_N stays 1 (null cycle).
- A SEL drop during ACCESS does not abort the access. The write commits. ACK is entered and exits on its first cycle, so DTACK_N pulses low for exactly one cycle.
- Latched request fields are frozen for the whole transaction. Requester inputs may change after IDLE sampling without effect.
- Reset values:
  - state=IDLE.
  - DTACK_N all 1.
  - DO=0.
  - VRAM_CE_N, VRAM_WE_N, VRAM_UB_N, VRAM_LB_N = 1.
  - VRAM_ADDR=0, VRAM_DI=0.
  - GRANT=0.
  - last_grant=NUM_PORTS-1, so port 0 has first priority.
- Reset asserted mid-transaction returns everything to the reset values immediately. No memory write completes after RST_N falls.

## Timing
- SEL sampled at edge k leads to ACCESS cycles k+1 … k+WAIT_STATES.
- DTACK_N goes low after edge k+WAIT_STATES+1 and DO is valid in the same cycle.
- Request-to-ack latency is WAIT_STATES+1 cycles. With WAIT_STATES=1 this is one memory cycle plus ack.
- DTACK_N returns to 1 the cycle after SEL[winner]=0 is sampled. The next IDLE arbitration happens on the following edge, so the minimum gap between transactions is one IDLE cycle.
- Back-to-back transactions from the same port require that port to drop SEL for at least one cycle.
- With all ports requesting continuously, grants rotate 0,1,…,N-1,0. No port waits more than N-1 transactions.
- Two ports requesting in the same IDLE cycle: round-robin order decides. There is no fixed priority except immediately after reset.

## Test plan
- Reset: hold RST_N=0 with SEL=all 1 → DTACK_N=all 1, VRAM_CE_N=1, DO=0. Release → port 0 granted first.
- Single write, WAIT_STATES=1: port 0 writes 16'hA5C3 to 15'h0123 with both strobes → one cycle with CE_N=0, WE_N=0, VRAM_ADDR=15'h0123, VRAM_DI=16'hA5C3, then DTACK_N[0]=0 two edges after SEL is sampled.
- Byte write: port 1 writes with LDS_N=0, UDS_N=1 → VRAM_UB_N=1, VRAM_LB_N=0. Readback of that word via port 0 returns the old upper byte and the new lower byte.
- Wait states: WAIT_STATES=3, port 0 reads address 15'h7FFF → CE_N low for exactly 3 cycles, DTACK_N low after 4 edges, DO = model data.
- Fairness: NUM_PORTS=3, all SEL held and each released one cycle after its own DTACK → grant order 0,1,2,0,1,2. DTACK_N is never low on two ports at once.
- Abort and reset: SEL[1] dropped during ACCESS → write commits, DTACK_N[1] low for exactly 1 cycle. A separate RST_N pulse during ACCESS → strobes go high immediately and the memory model shows no write.
